// File: rtl/periph_uart_tx.sv
// UART transmitter for the CPU's memory-mapped PeripheralBuffer word.
// Sends each new word as two 8N1 bytes, low byte first. Intermediate values seen while busy are dropped.
module periph_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] PeripheralBuffer,
    output logic                    tx,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                  r_state, w_state_next;
    logic [2*DATA_WIDTH-1:0] r_last_sent, w_last_sent_next;
    logic [2*DATA_WIDTH-1:0] r_snapshot, w_snapshot_next;
    logic                    r_byte_sel, w_byte_sel_next;
    logic [BIT_W-1:0]        r_bit_idx, w_bit_idx_next;
    logic [BAUD_W-1:0]       r_baud_cnt, w_baud_cnt_next;
    logic                    r_tx, w_tx_next;
    logic                    r_busy, w_busy_next;
    logic                    r_frame_done, w_frame_done_next;

    logic                    w_baud_last;
    logic [BIT_W-1:0]        w_bit_idx_inc;
    logic [DATA_WIDTH-1:0]   w_cur_byte;

    assign w_baud_last   = (r_baud_cnt == BAUD_LAST);
    assign w_bit_idx_inc = r_bit_idx + 1'b1;
    assign w_cur_byte    = r_byte_sel ? r_snapshot[2*DATA_WIDTH-1:DATA_WIDTH]
                                      : r_snapshot[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_sent  <= '0;
            r_snapshot   <= '0;
            r_byte_sel   <= 1'b0;
            r_bit_idx    <= '0;
            r_baud_cnt   <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_sent  <= w_last_sent_next;
            r_snapshot   <= w_snapshot_next;
            r_byte_sel   <= w_byte_sel_next;
            r_bit_idx    <= w_bit_idx_next;
            r_baud_cnt   <= w_baud_cnt_next;
            r_tx         <= w_tx_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_sent_next  = r_last_sent;
        w_snapshot_next   = r_snapshot;
        w_byte_sel_next   = r_byte_sel;
        w_bit_idx_next    = r_bit_idx;
        w_baud_cnt_next   = w_baud_last ? '0 : r_baud_cnt + 1'b1;
        w_tx_next         = r_tx;
        w_busy_next       = r_busy;
        w_frame_done_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_cnt_next = '0;
                // Compare against the live word so values changed during a frame coalesce.
                if (PeripheralBuffer != r_last_sent) begin
                    w_snapshot_next  = PeripheralBuffer;
                    w_last_sent_next = PeripheralBuffer;
                    w_byte_sel_next  = 1'b0;
                    w_bit_idx_next   = '0;
                    w_tx_next        = 1'b0;
                    w_busy_next      = 1'b1;
                    w_state_next     = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_bit_idx_next = '0;
                    w_tx_next      = w_cur_byte[0];
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    if (r_bit_idx == BIT_LAST) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = w_bit_idx_inc;
                        w_tx_next      = w_cur_byte[w_bit_idx_inc];
                    end
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    if (!r_byte_sel) begin
                        w_byte_sel_next = 1'b1;
                        w_tx_next       = 1'b0;
                        w_state_next    = S_START;
                    end else begin
                        w_busy_next       = 1'b0;
                        w_frame_done_next = 1'b1;
                        w_state_next      = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_periph_uart_tx.sv
// Directed + randomized bench for periph_uart_tx at 4 clocks per bit.
// The expected line is computed per clock from the 8N1 framing rules.
module tb_periph_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME_CLKS = 20 * CPB;

    logic        clk;
    logic        rst;
    logic [15:0] pb;
    logic        tx;
    logic        busy;
    logic        frame_done;

    int          n_checks;
    int          n_errors;
    logic [15:0] model_last;
    logic [FRAME_CLKS-1:0] cap;

    periph_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .PeripheralBuffer(pb),
        .tx              (tx),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level k clocks after the start-bit fall for a two-byte 8N1 frame of word w.
    function automatic logic exp_tx(input logic [15:0] w, input int k);
        int         slot;
        int         pos;
        logic [7:0] b;
        slot = k / CPB;
        b    = (slot < 10) ? w[7:0] : w[15:8];
        pos  = slot % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: {tx,busy,frame_done} got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic sample(input string tag, input logic [2:0] exp);
        @(negedge clk);
        check3(tag, {tx, busy, frame_done}, exp);
    endtask

    task automatic slots(input logic [15:0] w, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            @(negedge clk);
            cap[k] = tx;
            check3($sformatf("frame_%h_k%0d", w, k), {tx, busy, frame_done},
                   {exp_tx(w, k), 1'b1, 1'b0});
        end
    endtask

    task automatic frame_end(input logic [15:0] w);
        logic [15:0] dec;
        sample("frame_end", 3'b101);
        for (int i = 0; i < 8; i++) begin
            dec[i]   = cap[CPB*(1+i) + CPB/2];
            dec[8+i] = cap[CPB*(11+i) + CPB/2];
        end
        n_checks++;
        assert (dec === w) else begin
            n_errors++;
            $error("FAIL decode: got %h want %h", dec, w);
        end
        $display("frame sent: want %h decoded %h", w, dec);
        model_last = w;
    endtask

    task automatic check_frame(input logic [15:0] w);
        slots(w, 0, FRAME_CLKS);
        frame_end(w);
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) sample(tag, 3'b100);
        $display("idle %0d cycles: %s", n, tag);
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        int          k1;
        int          k2;

        n_checks   = 0;
        n_errors   = 0;
        model_last = 16'h0000;
        cap        = '0;
        rst        = 1'b1;
        pb         = 16'h0000;

        // 1: reset, word equal to cleared last_sent
        repeat (3) @(posedge clk);
        sample("reset_state", 3'b100);
        rst = 1'b0;
        quiet(200, "after_reset");

        // 2: power-on RAM value
        pb = 16'haaaa;
        check_frame(16'haaaa);
        quiet(10, "after_aaaa");

        // 3: bytes 34 then 12, no resend afterwards
        pb = 16'h1234;
        check_frame(16'h1234);
        quiet(20, "after_1234");

        // random words, including a rewrite of the last value
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            if (i == 2) w = model_last;
            pb = w;
            if (w == model_last) begin
                quiet(40, "same_word");
            end else begin
                check_frame(w);
                quiet(2, "after_rand");
            end
        end

        // random coalescing: only the final value of a busy period is sent next
        a = 16'($urandom);
        if (a == model_last) a = a ^ 16'h0001;
        b = 16'($urandom);
        c = 16'($urandom);
        if (c == a) c = c ^ 16'h8000;
        if (c == 16'h1234) c = c ^ 16'h0100;
        k1 = int'($urandom_range(5, 35));
        k2 = int'($urandom_range(40, 75));
        pb = a;
        slots(a, 0, k1);
        pb = b;
        slots(a, k1, k2);
        pb = c;
        slots(a, k2, FRAME_CLKS);
        frame_end(a);
        check_frame(c);
        quiet(5, "after_coalesce");

        // 4: 5678 is overwritten before the bus frees
        pb = 16'h1234;
        slots(16'h1234, 0, 30);
        pb = 16'h5678;
        slots(16'h1234, 30, 60);
        pb = 16'h9abc;
        slots(16'h1234, 60, FRAME_CLKS);
        frame_end(16'h1234);
        check_frame(16'h9abc);
        quiet(20, "after_9abc");

        // 5: reset during data bit 5 of the low byte
        pb = 16'h1234;
        slots(16'h1234, 0, CPB*6 + 2);
        rst = 1'b1;
        sample("reset_abort", 3'b100);
        rst = 1'b0;
        check_frame(16'h1234);

        // 6: rewrite of the same word
        pb = 16'h1234;
        quiet(200, "rewrite_same");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
